// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor snooping register-file writeback for the riscv-tests x3/x26/x27 convention.
// Optional watchdog enabled by defining MONITOR_TIMEOUT_EN.
module riscv_test_monitor #(
  parameter int unsigned SETTLE_CYCLES  = 10,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TESTNUM_REG    = 3,
  parameter int unsigned DONE_REG       = 26,
  parameter int unsigned PASS_REG       = 27
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_waddr,
  input  logic [31:0] i_wb_wdata,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_fail,
  output logic [31:0] o_fail_testnum,
  output logic        o_timeout,
  output logic [31:0] o_cycle_count
);

  // state  | meaning
  // RUN    | test executing, waiting for x26 <= 1
  // SETTLE | done seen, settle down-counter running
  // DONE   | verdict latched, everything frozen until reset

  typedef enum logic [1:0] {S_RUN, S_SETTLE, S_DONE} state_t;

  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

  state_t        r_state;
  logic [SW-1:0] r_settle_cnt;
  logic [31:0]   r_sh_testnum;
  logic [31:0]   r_sh_pass;
  logic [31:0]   r_cycle_count;
  logic          r_done;
  logic          r_pass;
  logic          r_fail;
  logic [31:0]   r_fail_testnum;
  logic          r_timeout;

  logic        w_wr_testnum;
  logic        w_wr_pass;
  logic        w_done_set;
  logic        w_pass_now;
  logic        w_timeout_hit;
  logic [31:0] w_cnt_next;

  // Only the x26 <= 1 event matters, so no done shadow is kept.
  assign w_wr_testnum = i_wb_we && (TESTNUM_REG != 0) && (i_wb_waddr == 5'(TESTNUM_REG));
  assign w_wr_pass    = i_wb_we && (PASS_REG != 0)    && (i_wb_waddr == 5'(PASS_REG));
  assign w_done_set   = i_wb_we && (DONE_REG != 0)    && (i_wb_waddr == 5'(DONE_REG))
                        && (i_wb_wdata == 32'd1);
  assign w_pass_now   = (r_sh_pass == 32'd1);
  assign w_cnt_next   = (r_cycle_count == 32'hFFFF_FFFF) ? r_cycle_count
                                                         : r_cycle_count + 32'd1;

`ifdef MONITOR_TIMEOUT_EN
  assign w_timeout_hit = ({1'b0, w_cnt_next} >= 33'(TIMEOUT_CYCLES));
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_RUN;
      r_settle_cnt   <= '0;
      r_sh_testnum   <= '0;
      r_sh_pass      <= '0;
      r_cycle_count  <= '0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_fail         <= 1'b0;
      r_fail_testnum <= '0;
      r_timeout      <= 1'b0;
    end else begin
      if (r_state != S_DONE) begin
        if (w_wr_testnum) r_sh_testnum <= i_wb_wdata;
        if (w_wr_pass)    r_sh_pass    <= i_wb_wdata;
        r_cycle_count <= w_cnt_next;
      end
      case (r_state)
        S_RUN: begin
          if (w_timeout_hit) begin
            r_state        <= S_DONE;
            r_done         <= 1'b1;
            r_fail         <= 1'b1;
            r_timeout      <= 1'b1;
            r_fail_testnum <= r_sh_testnum;
          end else if (w_done_set) begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= SETTLE_LOAD;
          end
        end
        S_SETTLE: begin
          // Verdict uses pre-edge shadows; settle expiry beats the watchdog.
          if (r_settle_cnt == '0) begin
            r_state        <= S_DONE;
            r_done         <= 1'b1;
            r_pass         <= w_pass_now;
            r_fail         <= ~w_pass_now;
            r_fail_testnum <= r_sh_testnum;
          end else if (w_timeout_hit) begin
            r_state        <= S_DONE;
            r_done         <= 1'b1;
            r_fail         <= 1'b1;
            r_timeout      <= 1'b1;
            r_fail_testnum <= r_sh_testnum;
          end else begin
            r_settle_cnt <= r_settle_cnt - SW'(1);
          end
        end
        S_DONE: ;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign o_done         = r_done;
  assign o_pass         = r_pass;
  assign o_fail         = r_fail;
  assign o_fail_testnum = r_fail_testnum;
  assign o_timeout      = r_timeout;
  assign o_cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: default instance plus a SETTLE_CYCLES=0 / TIMEOUT_CYCLES=50 instance.
module tb_riscv_test_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we [2];
  logic [4:0]  waddr [2];
  logic [31:0] wdata [2];
  logic        done [2];
  logic        pass [2];
  logic        fail [2];
  logic [31:0] ftn [2];
  logic        tmo [2];
  logic [31:0] ccnt [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_test_monitor dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_we(we[0]), .i_wb_waddr(waddr[0]), .i_wb_wdata(wdata[0]),
    .o_done(done[0]), .o_pass(pass[0]), .o_fail(fail[0]),
    .o_fail_testnum(ftn[0]), .o_timeout(tmo[0]), .o_cycle_count(ccnt[0])
  );

  riscv_test_monitor #(.SETTLE_CYCLES(0), .TIMEOUT_CYCLES(50)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_we(we[1]), .i_wb_waddr(waddr[1]), .i_wb_wdata(wdata[1]),
    .o_done(done[1]), .o_pass(pass[1]), .o_fail(fail[1]),
    .o_fail_testnum(ftn[1]), .o_timeout(tmo[1]), .o_cycle_count(ccnt[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input int sel, input logic [4:0] a, input logic [31:0] d);
    we[sel] = 1'b1; waddr[sel] = a; wdata[sel] = d;
    @(posedge clk);
    #1;
    we[sel] = 1'b0; waddr[sel] = '0; wdata[sel] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    #2;
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      we[s] = 1'b0; waddr[s] = '0; wdata[s] = '0;
    end

    // Reset state
    #2;
    check("rst_done", {31'd0, done[0]}, 32'd0);
    check("rst_pass", {31'd0, pass[0]}, 32'd0);
    check("rst_fail", {31'd0, fail[0]}, 32'd0);
    check("rst_ccnt", ccnt[0], 32'd0);
    do_reset();

    // Pass path: E = edge 3, verdict after edge 14
    wb_write(0, 5'd3, 32'd5);
    wb_write(0, 5'd27, 32'd1);
    wb_write(0, 5'd26, 32'd1);
    tick(10);
    check("pass_done_e10", {31'd0, done[0]}, 32'd0);
    tick(1);
    check("pass_done_e11", {31'd0, done[0]}, 32'd1);
    check("pass_pass", {31'd0, pass[0]}, 32'd1);
    check("pass_fail", {31'd0, fail[0]}, 32'd0);
    check("pass_testnum", ftn[0], 32'd5);
    check("pass_timeout", {31'd0, tmo[0]}, 32'd0);
    check("pass_ccnt", ccnt[0], 32'd14);

    // Sticky after DONE
    wb_write(0, 5'd27, 32'd0);
    wb_write(0, 5'd26, 32'd1);
    tick(5);
    check("sticky_pass", {31'd0, pass[0]}, 32'd1);
    check("sticky_fail", {31'd0, fail[0]}, 32'd0);
    check("sticky_ccnt", ccnt[0], 32'd14);

    // Fail path
    do_reset();
    wb_write(0, 5'd3, 32'd7);
    wb_write(0, 5'd27, 32'd0);
    wb_write(0, 5'd26, 32'd1);
    tick(11);
    check("fail_done", {31'd0, done[0]}, 32'd1);
    check("fail_fail", {31'd0, fail[0]}, 32'd1);
    check("fail_pass", {31'd0, pass[0]}, 32'd0);
    check("fail_testnum", ftn[0], 32'd7);

    // x3 updated during SETTLE, done re-write does not restart the counter
    do_reset();
    wb_write(0, 5'd3, 32'd7);
    wb_write(0, 5'd27, 32'd0);
    wb_write(0, 5'd26, 32'd1);
    wb_write(0, 5'd3, 32'd9);
    wb_write(0, 5'd26, 32'd1);
    tick(8);
    check("rew_done_e10", {31'd0, done[0]}, 32'd0);
    tick(1);
    check("rew_done_e11", {31'd0, done[0]}, 32'd1);
    check("rew_testnum", ftn[0], 32'd9);

    // PASS_REG write on the final SETTLE edge: old value wins
    do_reset();
    wb_write(0, 5'd27, 32'd1);
    wb_write(0, 5'd26, 32'd1);
    tick(10);
    wb_write(0, 5'd27, 32'd0);
    check("late_done", {31'd0, done[0]}, 32'd1);
    check("late_pass", {31'd0, pass[0]}, 32'd1);

    // Filtering
    do_reset();
    wb_write(0, 5'd3, 32'd4);
    wb_write(0, 5'd27, 32'd1);
    wb_write(0, 5'd26, 32'd2);
    tick(15);
    check("filt_val2", {31'd0, done[0]}, 32'd0);
    we[0] = 1'b0; waddr[0] = 5'd26; wdata[0] = 32'd1;
    tick(15);
    waddr[0] = '0; wdata[0] = '0;
    check("filt_we0", {31'd0, done[0]}, 32'd0);
    wb_write(0, 5'd0, 32'd1);
    wb_write(0, 5'd26, 32'd1);
    tick(11);
    check("filt_done", {31'd0, done[0]}, 32'd1);
    check("filt_pass", {31'd0, pass[0]}, 32'd1);
    check("filt_testnum", ftn[0], 32'd4);
    check("filt_ccnt", ccnt[0], 32'd46);

    // Reset mid-SETTLE, then a clean pass sequence
    do_reset();
    wb_write(0, 5'd27, 32'd1);
    wb_write(0, 5'd26, 32'd1);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("midrst_done", {31'd0, done[0]}, 32'd0);
    check("midrst_ccnt", ccnt[0], 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wb_write(0, 5'd3, 32'd11);
    wb_write(0, 5'd27, 32'd1);
    wb_write(0, 5'd26, 32'd1);
    tick(10);
    check("after_done_e10", {31'd0, done[0]}, 32'd0);
    tick(1);
    check("after_pass", {31'd0, pass[0]}, 32'd1);
    check("after_testnum", ftn[0], 32'd11);
    check("after_ccnt", ccnt[0], 32'd14);

    // SETTLE_CYCLES=0: verdict after E+1
    do_reset();
    wb_write(1, 5'd27, 32'd1);
    wb_write(1, 5'd26, 32'd1);
    check("s0_done_e0", {31'd0, done[1]}, 32'd0);
    tick(1);
    check("s0_done_e1", {31'd0, done[1]}, 32'd1);
    check("s0_pass", {31'd0, pass[1]}, 32'd1);

    // Watchdog
    do_reset();
`ifdef MONITOR_TIMEOUT_EN
    tick(49);
    check("wd_done_e49", {31'd0, done[1]}, 32'd0);
    tick(1);
    check("wd_done", {31'd0, done[1]}, 32'd1);
    check("wd_fail", {31'd0, fail[1]}, 32'd1);
    check("wd_pass", {31'd0, pass[1]}, 32'd0);
    check("wd_timeout", {31'd0, tmo[1]}, 32'd1);
    check("wd_ccnt", ccnt[1], 32'd50);
`else
    tick(200);
    check("nowd_done", {31'd0, done[1]}, 32'd0);
    check("nowd_timeout", {31'd0, tmo[1]}, 32'd0);
    check("nowd_ccnt", ccnt[1], 32'd200);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
- Synthesizable pass/fail monitor sitting directly downstream of the CPU core's register-file writeback port inside the SoC.
- Snoops writeback for the riscv-tests convention:
  - x3 = current test number
  - x26 = done flag
  - x27 = pass flag
- After done, waits a settle window, then latches a sticky verdict.
- Lets directed ISA tests self-check on FPGA and in simulation without hierarchical register peeking.

Parameters:
- SETTLE_CYCLES, 10: clock cycles waited after the done write before evaluating the pass flag.
- TIMEOUT_CYCLES, 100000: watchdog limit in cycles (used only with the optional feature).
- TESTNUM_REG, 3: register index tracked as the test number.
- DONE_REG, 26: register index whose write of 1 ends the test.
- PASS_REG, 27: register index holding the pass flag (1 = pass).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- wb_we  input  1  register-file write enable from the core writeback stage.
- wb_waddr  input  5  writeback destination register index.
- wb_wdata  input  32  writeback data.
- done  output  1  verdict valid; sticky until reset.
- pass  output  1  test passed; valid when done=1.
- fail  output  1  test failed; valid when done=1.
- fail_testnum  output  32  shadow x3 value latched at verdict time.
- timeout  output  1  verdict caused by watchdog.
- cycle_count  output  32  cycles elapsed since reset release.

Behaviour:
- Reset (rst=0, async): state=RUN; all shadows, counters and outputs = 0.
- Shadow registers sh_testnum, sh_done, sh_pass:
  - Each updates at the clock edge where wb_we=1 and wb_waddr equals its parameter index; takes wb_wdata.
  - Writes to index 0 are ignored.
  - Shadows keep updating in RUN and SETTLE; frozen in DONE.
- FSM states RUN, SETTLE, DONE:
  - RUN: at an edge with wb_we=1, wb_waddr=DONE_REG, wb_wdata=32'd1, go to SETTLE and load settle_cnt=SETTLE_CYCLES. A done write of any other value only updates sh_done; no transition.
  - SETTLE: settle_cnt decrements by 1 each cycle. When settle_cnt==0 at an edge, go to DONE and latch the verdict in the same edge:
    - pass = (sh_pass==1)
    - fail = ~pass
    - fail_testnum = sh_testnum
  - DONE: terminal; outputs hold until reset.
- Latency: if the done write is sampled at edge E, done/pass/fail are high after edge E+SETTLE_CYCLES+1.
  - SETTLE_CYCLES=0 gives the verdict after E+1.
- PASS_REG write coinciding with the final SETTLE edge: the verdict uses the pre-edge shadow value (old data).
- Re-writes of done=1 while in SETTLE do not restart the counter.
- pass and fail are never both 1; both are 0 while done=0.
- cycle_count:
  - Increments every cycle in RUN and SETTLE; frozen in DONE.
  - Saturates at 32'hFFFF_FFFF (no wrap).
- Reset asserted mid-SETTLE or in DONE returns immediately to RUN with all outputs 0.

Optional Feature:
- Macro MONITOR_TIMEOUT_EN.
- Defined: watchdog active. In RUN or SETTLE, when cycle_count reaches TIMEOUT_CYCLES (before any verdict), go to DONE with:
  - done=1, fail=1, pass=0, timeout=1
  - fail_testnum = sh_testnum
- If the settle expiry and the timeout occur on the same edge, the settle verdict wins and timeout=0.
- Not defined: no watchdog logic; timeout tied to 0; monitor waits indefinitely in RUN.

Test Plan:
- Pass path: write x3=5, x27=1, then x26=1 at edge E (SETTLE_CYCLES=10) -> done=1, pass=1, fail=0 after edge E+11; done=0 after edge E+10.
- Fail path: write x3=7, x27=0, x26=1 -> done=1, fail=1, pass=0, fail_testnum=7; x3=9 written during SETTLE gives fail_testnum=9.
- Filtering:
  - x26=2 written -> state stays RUN, done=0.
  - Write with wb_we=0 to x26 -> ignored.
  - x0 write -> no shadow change.
  - Later x26=1 -> normal verdict.
- Reset mid-SETTLE: rst=0 five cycles after the done write -> all outputs 0 immediately; after release, a new pass sequence completes normally.
- Sticky/saturation: after DONE, write x27=0 and x26=1 -> pass stays 1 and cycle_count stays frozen.
- With MONITOR_TIMEOUT_EN and TIMEOUT_CYCLES=50, no done write -> after edge 50, done=1, fail=1, timeout=1, cycle_count=50. Without the macro: timeout=0 and done=0 for 200 cycles.
